axi4_stream_shift_arbiter: RTL and testbench
============================================

AXI4_STREAM_SHIFT_ARBITER -- requirements
Module: axi4_stream_shift_arbiter

Interface
REQ-001 Parameter REQ_CNT, default 2: number of requesting streams sharing one byte shifter; SHALL be >= 2.
REQ-002 Parameter DATA_WIDTH, default 32: tdata width of all streams; DATA_WIDTH_B = DATA_WIDTH/8.
REQ-003 Parameters ID_WIDTH, DEST_WIDTH, USER_WIDTH, default 1: sideband widths of all streams.
REQ-004 Parameter DATA_WIDTH_B_W, default $clog2(DATA_WIDTH_B): width of each shift value.
REQ-005 clk_i  input  1  clock; all logic on rising edge.
REQ-006 rst_i  input  1  reset, asynchronous, active-high.
REQ-007 pkt_i  axi4_stream_if slave array [REQ_CNT]  requester streams.
REQ-008 shift_i  input  REQ_CNT*DATA_WIDTH_B_W  per-requester byte shift; slice k belongs to pkt_i[k].
REQ-009 pkt_o  axi4_stream_if master  stream to shifter ingress.
REQ-010 shift_o  output  DATA_WIDTH_B_W  registered shift value driving the shifter.
REQ-011 eg_tvalid_i, eg_tready_i, eg_tlast_i  input  1 each  monitor of shifter egress handshake.
REQ-012 grant_o  output  REQ_CNT  one-hot current grant, zero when idle.
REQ-013 busy_o  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, PASS, DRAIN.
REQ-015 IDLE: when any pkt_i[k].tvalid is high, SHALL select one requester round-robin, starting search at rr_ptr, and go to PASS next cycle.
REQ-016 On grant SHALL register grant_o (one-hot) and shift_o = shift_i slice of the winner, same edge as entering PASS.
REQ-017 Arbitration latency SHALL be exactly one cycle: first beat can reach pkt_o in the cycle after tvalid is seen in IDLE.
REQ-018 PASS: pkt_o tvalid/tdata/tkeep/tstrb/tlast/tid/tdest/tuser SHALL combinationally equal those of the granted pkt_i; granted tready SHALL equal pkt_o.tready; all other tready SHALL be 0.
REQ-019 PASS -> DRAIN on pkt_o.tvalid && pkt_o.tready && pkt_o.tlast; in DRAIN pkt_o.tvalid and all pkt_i tready SHALL be 0.
REQ-020 DRAIN -> IDLE on eg_tvalid_i && eg_tready_i && eg_tlast_i; rr_ptr SHALL become (granted index + 1) mod REQ_CNT on that edge; grant_o SHALL clear.
REQ-021 shift_o SHALL stay constant from grant until leaving DRAIN, so the shifter sees one shift value for a whole packet including its trailing backpressure beat.
REQ-022 Egress tlast handshake seen in IDLE or PASS SHALL be ignored.
REQ-023 Requester dropping tvalid mid-packet SHALL not release the grant; only tlast does.
REQ-024 Single-beat packet (tlast on first beat) SHALL go PASS -> DRAIN after one beat.
REQ-025 Requester valid in IDLE while rr_ptr points elsewhere with no valid SHALL win (no idle cycles wasted on empty requesters).
REQ-026 Sideband and data SHALL not be registered (zero added data latency in PASS).

Reset
REQ-027 On rst_i high: state IDLE, rr_ptr 0, grant_o 0, shift_o 0, busy_o 0, pkt_o.tvalid 0, all pkt_i tready 0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet immediately; after release arbitration restarts from requester 0.

Verification
REQ-029 REQ_CNT=2, both valid from reset, 3-beat packets, shift 1/3 -> req0 granted first with shift_o=1, then req1 with shift_o=3, alternating.
REQ-030 req1 single 1-beat packet, shift_i=2, eg tlast returned 2 cycles after ingress tlast -> busy_o high 4 cycles total, req0 tready 0 throughout.
REQ-031 pkt_o.tready toggled randomly during 8-beat packet -> all 8 beats arrive in order, no beat duplicated or dropped, shift_o constant.
REQ-032 Granted requester deasserts tvalid 5 cycles mid-packet while other valid -> grant unchanged until tlast.
REQ-033 rst_i pulsed on beat 2 of req1 packet -> next cycle all tready 0, grant_o 0; after release req0 wins if both valid.
REQ-034 Egress tlast pulse injected while in PASS -> no state change, grant held until ingress tlast then egress tlast.

Source files
------------

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle shared by the shift arbiter and its neighbours.
//   master modport : drives tvalid/tdata/tkeep/tstrb/tlast/tid/tdest/tuser, samples tready
//   slave modport  : samples the payload, drives tready
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  localparam int DATA_WIDTH_B = DATA_WIDTH / 8;

  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH_B-1:0] tkeep;
  logic [DATA_WIDTH_B-1:0] tstrb;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi4_stream_shift_arbiter.sv
// Round-robin arbiter letting REQ_CNT streams share one byte shifter.
// A winner owns the shifter from grant until the shifter's egress reports
// the packet's last beat, so one shift value covers the whole packet,
// including any beat the shifter still holds after ingress tlast.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous, active-high reset
//   pkt_i[k]     requester streams (slave)
//   shift_i      per-requester byte shift, slice k belongs to pkt_i[k]
//   pkt_o        stream to the shifter ingress (master), unregistered mux
//   shift_o      registered shift value held for the owning packet
//   eg_t*_i      monitor of the shifter egress handshake
//   grant_o      one-hot owner, zero when idle
//   busy_o       high whenever the shifter is owned
module axi4_stream_shift_arbiter #(
  parameter int REQ_CNT        = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 1,
  parameter int DEST_WIDTH     = 1,
  parameter int USER_WIDTH     = 1,
  parameter int DATA_WIDTH_B_W = $clog2(DATA_WIDTH / 8)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  axi4_stream_if.slave                      pkt_i [REQ_CNT],
  input  logic [REQ_CNT*DATA_WIDTH_B_W-1:0] shift_i,
  axi4_stream_if.master                     pkt_o,
  output logic [DATA_WIDTH_B_W-1:0]         shift_o,
  input  logic                              eg_tvalid_i,
  input  logic                              eg_tready_i,
  input  logic                              eg_tlast_i,
  output logic [REQ_CNT-1:0]                grant_o,
  output logic                              busy_o
);

  localparam int DATA_WIDTH_B = DATA_WIDTH / 8;
  localparam int IDX_W        = $clog2(REQ_CNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_DRAIN
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;

  // Flattened copies of the requester streams so they can be indexed by a
  // run-time grant index (interface arrays only take constant indices).
  logic [REQ_CNT-1:0]      req_valid;
  logic [REQ_CNT-1:0]      req_last;
  logic [DATA_WIDTH-1:0]   req_data [REQ_CNT];
  logic [DATA_WIDTH_B-1:0] req_keep [REQ_CNT];
  logic [DATA_WIDTH_B-1:0] req_strb [REQ_CNT];
  logic [ID_WIDTH-1:0]     req_id   [REQ_CNT];
  logic [DEST_WIDTH-1:0]   req_dest [REQ_CNT];
  logic [USER_WIDTH-1:0]   req_user [REQ_CNT];

  logic pass_st;
  assign pass_st = (state == ST_PASS);

  for (genvar g = 0; g < REQ_CNT; g++) begin : g_req
    assign req_valid[g] = pkt_i[g].tvalid;
    assign req_last[g]  = pkt_i[g].tlast;
    assign req_data[g]  = pkt_i[g].tdata;
    assign req_keep[g]  = pkt_i[g].tkeep;
    assign req_strb[g]  = pkt_i[g].tstrb;
    assign req_id[g]    = pkt_i[g].tid;
    assign req_dest[g]  = pkt_i[g].tdest;
    assign req_user[g]  = pkt_i[g].tuser;
    // Only the owner sees backpressure release, and only while passing;
    // DRAIN stalls everyone until the shifter has emptied.
    assign pkt_i[g].tready = pass_st & grant_o[g] & pkt_o.tready;
  end

  // Payload mux: zero added latency, the owner's beat goes straight through.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    pkt_o.tvalid = 1'b0;
    pkt_o.tdata  = '0;
    pkt_o.tkeep  = '0;
    pkt_o.tstrb  = '0;
    pkt_o.tlast  = 1'b0;
    pkt_o.tid    = '0;
    pkt_o.tdest  = '0;
    pkt_o.tuser  = '0;
    if (pass_st) begin
      pkt_o.tvalid = req_valid[grant_idx];
      pkt_o.tdata  = req_data[grant_idx];
      pkt_o.tkeep  = req_keep[grant_idx];
      pkt_o.tstrb  = req_strb[grant_idx];
      pkt_o.tlast  = req_last[grant_idx];
      pkt_o.tid    = req_id[grant_idx];
      pkt_o.tdest  = req_dest[grant_idx];
      pkt_o.tuser  = req_user[grant_idx];
    end
  end

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  logic                      sel_found;
  logic [IDX_W-1:0]          sel_idx;
  logic [DATA_WIDTH_B_W-1:0] sel_shift;
  int                        cand;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int i = 0; i < REQ_CNT; i++) begin
      cand = (int'(rr_ptr) + i) % REQ_CNT;
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
    sel_shift = shift_i[int'(sel_idx)*DATA_WIDTH_B_W +: DATA_WIDTH_B_W];
  end

  logic             eg_last_hs;
  logic             in_last_hs;
  logic [IDX_W-1:0] next_ptr;

  assign eg_last_hs = eg_tvalid_i & eg_tready_i & eg_tlast_i;
  assign in_last_hs = pkt_o.tvalid & pkt_o.tready & pkt_o.tlast;
  assign next_ptr   = (grant_idx == IDX_W'(REQ_CNT - 1)) ? '0 : grant_idx + IDX_W'(1);

  // NOTE: reset here is asynchronous and active-high so an abandoned packet
  // drops tready/tvalid immediately, without waiting for a clock edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      grant_o   <= '0;
      shift_o   <= '0;
      busy_o    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            state     <= ST_PASS;
            grant_idx <= sel_idx;
            grant_o   <= REQ_CNT'(1) << sel_idx;
            shift_o   <= sel_shift;
            busy_o    <= 1'b1;
          end
        end
        ST_PASS: begin
          // Only ingress tlast ends the pass; tvalid gaps and stray egress
          // tlast pulses leave ownership untouched.
          if (in_last_hs) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (eg_last_hs) begin
            state   <= ST_IDLE;
            rr_ptr  <= next_ptr;
            grant_o <= '0;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_o <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_stream_shift_arbiter.sv
// Self-checking bench for axi4_stream_shift_arbiter (REQ_CNT=2, 32-bit data).
// An ownership model predicts who holds the shifter; one negedge process
// compares every DUT output against it, and directed scenarios pin the
// model with literal grant orders, beat orders and busy lengths.
module tb_axi4_stream_shift_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int SW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            gap;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N*SW-1:0] shift_i;
  logic [SW-1:0] shift_o;
  logic          eg_tvalid_i, eg_tready_i, eg_tlast_i;
  logic [N-1:0]  grant_o;
  logic          busy_o;
  logic          out_ready;

  always #5 clk_i = ~clk_i;

  axi4_stream_if #(.DATA_WIDTH(DW)) pkt_if [N] ();
  axi4_stream_if #(.DATA_WIDTH(DW)) out_if ();

  logic          src_valid  [N];
  logic [DW-1:0] src_data   [N];
  logic [KW-1:0] src_keep   [N];
  logic          src_last   [N];
  logic          src_tready [N];

  for (genvar g = 0; g < N; g++) begin : g_src
    assign pkt_if[g].tvalid = src_valid[g];
    assign pkt_if[g].tdata  = src_data[g];
    assign pkt_if[g].tkeep  = src_keep[g];
    assign pkt_if[g].tstrb  = src_keep[g];
    assign pkt_if[g].tlast  = src_last[g];
    assign pkt_if[g].tid    = 1'(g);
    assign pkt_if[g].tdest  = src_data[g][1];
    assign pkt_if[g].tuser  = src_data[g][2];
    assign src_tready[g]    = pkt_if[g].tready;
  end
  assign out_if.tready = out_ready;

  axi4_stream_shift_arbiter #(
    .REQ_CNT(N), .DATA_WIDTH(DW), .ID_WIDTH(1), .DEST_WIDTH(1),
    .USER_WIDTH(1), .DATA_WIDTH_B_W(SW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pkt_i       (pkt_if),
    .shift_i     (shift_i),
    .pkt_o       (out_if),
    .shift_o     (shift_o),
    .eg_tvalid_i (eg_tvalid_i),
    .eg_tready_i (eg_tready_i),
    .eg_tlast_i  (eg_tlast_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus sources ----------------
  beat_t src_q [N][$];
  bit    rand_ready = 1'b0;
  bit    inject_req = 1'b0;
  int    eg_delay   = 2;

  task automatic push_pkt(input int k, input logic [DW-1:0] base, input int nb,
                          input int gap_at, input int gap_len);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.data = base + DW'(i);
      b.keep = (i == nb - 1) ? 4'b0111 : 4'b1111;
      b.last = (i == nb - 1);
      b.gap  = (i == gap_at) ? gap_len : 0;
      src_q[k].push_back(b);
    end
  endtask

  // Drives sources, ingress ready and the egress monitor one step after each
  // rising edge; acceptance is sampled on the falling edge before it.
  initial begin
    bit    acc [N];
    bit    ing_last;
    bit    eg_pulse;
    int    eg_cnt;
    beat_t h;
    eg_cnt = 0;
    for (int k = 0; k < N; k++) begin
      src_valid[k] = 1'b0;
      src_data[k]  = '0;
      src_keep[k]  = '0;
      src_last[k]  = 1'b0;
    end
    out_ready   = 1'b1;
    eg_tvalid_i = 1'b0;
    eg_tready_i = 1'b0;
    eg_tlast_i  = 1'b0;
    forever begin
      @(negedge clk_i);
      for (int k = 0; k < N; k++) acc[k] = src_valid[k] && src_tready[k];
      ing_last = out_if.tvalid && out_if.tready && out_if.tlast;
      @(posedge clk_i);
      #1;
      for (int k = 0; k < N; k++)
        if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      for (int k = 0; k < N; k++) begin
        if (src_q[k].size() > 0) begin
          h = src_q[k][0];
          if (h.gap > 0) begin
            src_valid[k] = 1'b0;
            h.gap = h.gap - 1;
            src_q[k][0] = h;
          end else begin
            src_valid[k] = 1'b1;
            src_data[k]  = h.data;
            src_keep[k]  = h.keep;
            src_last[k]  = h.last;
          end
        end else begin
          src_valid[k] = 1'b0;
        end
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      // Shifter stand-in: egress tlast arrives eg_delay cycles after the
      // first DRAIN cycle.
      eg_pulse = 1'b0;
      if (rst_i) eg_cnt = 0;
      else begin
        if (ing_last) eg_cnt = eg_delay + 1;
        if (eg_cnt > 0) begin
          eg_cnt = eg_cnt - 1;
          if (eg_cnt == 0) eg_pulse = 1'b1;
        end
      end
      if (inject_req) begin
        eg_pulse   = 1'b1;
        inject_req = 1'b0;
      end
      eg_tvalid_i = eg_pulse;
      eg_tready_i = eg_pulse;
      eg_tlast_i  = eg_pulse;
    end
  end

  // ---------------- ownership model ----------------
  // m_owner: requester holding the shifter (-1 = free); m_in_done: its
  // ingress tlast has gone through; m_next: where the next search starts.
  int            m_owner   = -1;
  bit            m_in_done = 1'b0;
  int            m_next    = 0;
  logic [SW-1:0] m_shift   = '0;

  function automatic int pick(input int start);
    for (int i = 0; i < N; i++)
      if (src_valid[(start + i) % N]) return (start + i) % N;
    return -1;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_owner   <= -1;
      m_in_done <= 1'b0;
      m_next    <= 0;
      m_shift   <= '0;
    end else if (m_owner < 0) begin
      if (pick(m_next) >= 0) begin
        m_owner <= pick(m_next);
        m_shift <= shift_i[pick(m_next)*SW +: SW];
      end
    end else if (!m_in_done) begin
      if (src_valid[m_owner] && out_ready && src_last[m_owner]) m_in_done <= 1'b1;
    end else if (eg_tvalid_i && eg_tready_i && eg_tlast_i) begin
      m_next    <= (m_owner + 1) % N;
      m_owner   <= -1;
      m_in_done <= 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [DW-1:0] rx_q [$];
  int            grant_log [$];
  bit            prev_busy    = 1'b0;
  int            busy_cnt     = 0;
  int            r0_ready_cnt = 0;
  bit            exp_pass;
  bit            exp_v;
  int            o;

  always @(negedge clk_i) begin
    if (rst_i) begin
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_grant", 64'(grant_o), 64'd0);
      check("rst_shift", 64'(shift_o), 64'd0);
      check("rst_tvalid", 64'(out_if.tvalid), 64'd0);
      for (int k = 0; k < N; k++) check("rst_tready", 64'(src_tready[k]), 64'd0);
    end else begin
      o        = m_owner;
      exp_pass = (o >= 0) && !m_in_done;
      exp_v    = exp_pass ? src_valid[o] : 1'b0;
      check("busy", 64'(busy_o), 64'(o >= 0));
      check("grant", 64'(grant_o), (o >= 0) ? (64'd1 << o) : 64'd0);
      if (o >= 0) check("shift", 64'(shift_o), 64'(m_shift));
      check("tvalid", 64'(out_if.tvalid), 64'(exp_v));
      if (exp_v) begin
        check("tdata", 64'(out_if.tdata), 64'(src_data[o]));
        check("tkeep", 64'(out_if.tkeep), 64'(src_keep[o]));
        check("tstrb", 64'(out_if.tstrb), 64'(src_keep[o]));
        check("tlast", 64'(out_if.tlast), 64'(src_last[o]));
        check("tid", 64'(out_if.tid), 64'(o[0]));
        check("tdest", 64'(out_if.tdest), 64'(src_data[o][1]));
        check("tuser", 64'(out_if.tuser), 64'(src_data[o][2]));
      end
      for (int k = 0; k < N; k++)
        check("tready", 64'(src_tready[k]), 64'(exp_pass && (k == o) && out_ready));
      if (out_if.tvalid && out_if.tready) rx_q.push_back(out_if.tdata);
    end
    if (busy_o && !prev_busy) grant_log.push_back(int'(grant_o) * 16 + int'(shift_o));
    prev_busy = busy_o;
    if (busy_o) busy_cnt++;
    if (src_tready[0]) r0_ready_cnt++;
  end

  task automatic wait_drained(input string name, input int budget);
    int n;
    n = 0;
    while ((src_q[0].size() > 0 || src_q[1].size() > 0 || m_owner >= 0) && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    check(name, 64'(n < budget), 64'd1);
    @(negedge clk_i);
  endtask

  initial begin
    int            n;
    bit            seen;
    logic [DW-1:0] exp_rx [$];
    int            exp_g  [$];

    // Both requesters hold 3-beat packets from reset; shifts 1 and 3.
    rst_i   = 1'b1;
    shift_i = {2'd3, 2'd1};
    push_pkt(0, 32'h10, 3, -1, 0);
    push_pkt(1, 32'h20, 3, -1, 0);
    push_pkt(0, 32'h30, 3, -1, 0);
    push_pkt(1, 32'h40, 3, -1, 0);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b0;
    wait_drained("alt_drain", 300);
    exp_g = '{32'h11, 32'h23, 32'h11, 32'h23};
    check("alt_grant_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("alt_grant_order", 64'(grant_log[i]), 64'(exp_g[i]));
    exp_rx = '{32'h10, 32'h11, 32'h12, 32'h20, 32'h21, 32'h22,
               32'h30, 32'h31, 32'h32, 32'h40, 32'h41, 32'h42};
    check("alt_beat_count", 64'(rx_q.size()), 64'd12);
    for (int i = 0; i < 12 && i < rx_q.size(); i++)
      check("alt_beat_order", 64'(rx_q[i]), 64'(exp_rx[i]));

    // Single-beat packet on req1 with shift 2: busy exactly 4 cycles.
    shift_i = {2'd2, 2'd1};
    busy_cnt = 0;
    r0_ready_cnt = 0;
    grant_log.delete();
    push_pkt(1, 32'h50, 1, -1, 0);
    wait_drained("single_drain", 100);
    check("single_busy_cycles", 64'(busy_cnt), 64'd4);
    check("single_req0_ready", 64'(r0_ready_cnt), 64'd0);
    check("single_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(32'h22));

    // 8-beat packet under random ingress backpressure.
    rx_q.delete();
    grant_log.delete();
    rand_ready = 1'b1;
    push_pkt(0, 32'h80, 8, -1, 0);
    wait_drained("bp_drain", 400);
    rand_ready = 1'b0;
    check("bp_beat_count", 64'(rx_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      check("bp_beat_order", 64'(rx_q[i]), 64'(32'h80 + i));
    check("bp_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(32'h11));

    // req1 (next in turn) stalls 5 cycles mid-packet while req0 waits.
    rx_q.delete();
    grant_log.delete();
    push_pkt(1, 32'h60, 6, 2, 5);
    push_pkt(0, 32'h70, 3, -1, 0);
    wait_drained("gap_drain", 300);
    exp_rx = '{32'h60, 32'h61, 32'h62, 32'h63, 32'h64, 32'h65, 32'h70, 32'h71, 32'h72};
    check("gap_beat_count", 64'(rx_q.size()), 64'd9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++)
      check("gap_beat_order", 64'(rx_q[i]), 64'(exp_rx[i]));
    check("gap_grant_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      check("gap_grant_first", 64'(grant_log[0]), 64'(32'h22));
      check("gap_grant_second", 64'(grant_log[1]), 64'(32'h11));
    end

    // Reset during beat 2 of a req1 packet.
    push_pkt(1, 32'hC0, 4, -1, 0);
    push_pkt(0, 32'hD0, 4, -1, 0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      @(negedge clk_i);
      n++;
      if (out_if.tvalid && out_if.tdata == 32'hC1) seen = 1'b1;
    end
    check("rst_beat2_seen", 64'(seen), 64'd1);
    #1 rst_i = 1'b1;
    #1;
    check("midrst_grant", 64'(grant_o), 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_tready0", 64'(src_tready[0]), 64'd0);
    check("midrst_tready1", 64'(src_tready[1]), 64'd0);
    check("midrst_tvalid", 64'(out_if.tvalid), 64'd0);
    for (int k = 0; k < N; k++) src_q[k].delete();
    repeat (2) @(posedge clk_i);
    #2;
    push_pkt(0, 32'hE0, 2, -1, 0);
    push_pkt(1, 32'hF0, 2, -1, 0);
    @(posedge clk_i);
    #2;
    grant_log.delete();
    rx_q.delete();
    rst_i = 1'b0;
    wait_drained("postrst_drain", 200);
    check("postrst_grant_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      check("postrst_first_req0", 64'(grant_log[0]), 64'(32'h11));
      check("postrst_second_req1", 64'(grant_log[1]), 64'(32'h22));
    end

    // Stray egress tlast while passing must not release the grant.
    rx_q.delete();
    push_pkt(0, 32'hA0, 5, -1, 0);
    n = 0;
    while (rx_q.size() < 2 && n < 50) begin
      @(posedge clk_i);
      n++;
    end
    check("stray_reach_beat2", 64'(rx_q.size() >= 2), 64'd1);
    inject_req = 1'b1;
    @(negedge clk_i);
    check("stray_pulse_driven", 64'(eg_tlast_i), 64'd1);
    check("stray_busy_held", 64'(busy_o), 64'd1);
    check("stray_grant_held", 64'(grant_o), 64'd1);
    wait_drained("stray_drain", 200);
    check("stray_beat_count", 64'(rx_q.size()), 64'd5);
    check("stray_last_beat", 64'(rx_q.size() > 0 ? rx_q[rx_q.size()-1] : '0), 64'(32'hA4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
